// File: rtl/bin2bcd_pkg.sv
// ============================================================================
// Module : bin2bcd_pkg
// Brief  : Shared FSM encoding and counter sizing for the bin2bcd_gen converter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bin2bcd_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OP   = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Bits needed to hold the values 0..bin_w inclusive.
  function automatic int cnt_w(input int bin_w);
    int w;
    w = 0;
    while ((1 << w) < (bin_w + 1)) w++;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_adj3.sv
// ============================================================================
// Module : bcd_adj3
// Brief  : Double-dabble digit correction; adds 3 to a BCD digit above 4.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bcd_adj3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit > 4'd4) ? (i_digit + 4'd3) : i_digit;

endmodule

`default_nettype wire

// File: rtl/bin2bcd_gen.sv
// ============================================================================
// Module : bin2bcd_gen
// Brief  : Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bin2bcd_gen
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W = 16,
  parameter int DIG   = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [BIN_W-1:0]   bin,
  output logic               ready,
  output logic               done_tick,
  output logic [4*DIG-1:0]   bcd,
  output logic               neg,
  output logic               ovf,
  output logic [DIG-1:0]     blank
);

  localparam int CNT_W = cnt_w(BIN_W);

  generate
    if (DIG < 1 || BIN_W < 4) begin : g_param_check
      $error("bin2bcd_gen: DIG must be >= 1 and BIN_W must be >= 4");
    end
  endgenerate

  logic [1:0]         state_q, state_d;
  logic [BIN_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4*DIG-1:0]   bcd_q, bcd_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;

  logic [4*DIG-1:0]   w_adj;
  logic [BIN_W-1:0]   w_mag;
  logic               w_is_neg;

  generate
    for (genvar gi = 0; gi < DIG; gi++) begin : g_adj
      bcd_adj3 u_adj (
        .i_digit (bcd_q[4*gi +: 4]),
        .o_digit (w_adj[4*gi +: 4])
      );
    end
  endgenerate

  // The most negative input negates to itself, which is already the right magnitude.
  assign w_is_neg = signed_mode & bin[BIN_W-1];
  assign w_mag    = w_is_neg ? ((~bin) + BIN_W'(1)) : bin;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = OP;
          shreg_d = w_mag;
          cnt_d   = CNT_W'(BIN_W);
          bcd_d   = '0;
          neg_d   = w_is_neg;
          ovf_d   = 1'b0;
        end
      end
      OP: begin
        // Adjusted chain shifts left; the bit leaving the top digit marks overflow.
        bcd_d   = {w_adj[4*DIG-2:0], shreg_q[BIN_W-1]};
        ovf_d   = ovf_q | w_adj[4*DIG-1];
        shreg_d = {shreg_q[BIN_W-2:0], 1'b0};
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    ready     = (state_q == IDLE);
    done_tick = (state_q == DONE);
  end

  always_comb begin
    logic zrun;
    zrun  = 1'b1;
    blank = '0;
    for (int i = DIG - 1; i >= 1; i--) begin
      zrun     = zrun & (bcd_q[4*i +: 4] == 4'd0);
      blank[i] = zrun;
    end
  end

  assign bcd = bcd_q;
  assign neg = neg_q;
  assign ovf = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_gen.sv
// ============================================================================
// Module : tb_bin2bcd_gen
// Brief  : Self-checking bench for bin2bcd_gen (5-digit and 4-digit instances).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_bin2bcd_gen;

  localparam int BIN_W = 16;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              signed_mode;
  logic [BIN_W-1:0]  bin;

  logic              ready5, done5, neg5, ovf5;
  logic [19:0]       bcd5;
  logic [4:0]        blank5;
  logic              ready4, done4, neg4, ovf4;
  logic [15:0]       bcd4;
  logic [3:0]        blank4;

  int n_checks;
  int n_errors;

  bin2bcd_gen #(.BIN_W(BIN_W), .DIG(5)) u_dut5 (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .signed_mode (signed_mode),
    .bin         (bin),
    .ready       (ready5),
    .done_tick   (done5),
    .bcd         (bcd5),
    .neg         (neg5),
    .ovf         (ovf5),
    .blank       (blank5)
  );

  bin2bcd_gen #(.BIN_W(BIN_W), .DIG(4)) u_dut4 (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .signed_mode (signed_mode),
    .bin         (bin),
    .ready       (ready4),
    .done_tick   (done4),
    .bcd         (bcd4),
    .neg         (neg4),
    .ovf         (ovf4),
    .blank       (blank4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: magnitude, modulo 10^dig, decimal digit split.
  task automatic model(input logic [BIN_W-1:0] b, input logic sm, input int dig,
                       output logic [39:0] e_bcd, output logic e_neg,
                       output logic e_ovf, output logic [9:0] e_blank);
    longint mag, lim, r;
    int d [10];
    bit allz;
    if (sm && b[BIN_W-1]) begin
      mag   = (longint'(1) << BIN_W) - longint'(b);
      e_neg = 1'b1;
    end else begin
      mag   = longint'(b);
      e_neg = 1'b0;
    end
    lim = 1;
    for (int i = 0; i < dig; i++) lim = lim * 10;
    e_ovf = (mag >= lim);
    r = mag % lim;
    e_bcd = '0;
    for (int i = 0; i < dig; i++) begin
      d[i] = int'(r % 10);
      r    = r / 10;
      e_bcd[4*i +: 4] = 4'(d[i]);
    end
    e_blank = '0;
    allz = 1'b1;
    for (int i = dig - 1; i >= 1; i--) begin
      allz = allz && (d[i] == 0);
      e_blank[i] = allz;
    end
  endtask

  task automatic check_results(input logic [BIN_W-1:0] b, input logic sm);
    logic [39:0] eb;
    logic en, eo;
    logic [9:0] ebl;
    model(b, sm, 5, eb, en, eo, ebl);
    check_val("bcd5",   64'(bcd5),   64'(eb[19:0]));
    check_val("neg5",   64'(neg5),   64'(en));
    check_val("ovf5",   64'(ovf5),   64'(eo));
    check_val("blank5", 64'(blank5), 64'(ebl[4:0]));
    model(b, sm, 4, eb, en, eo, ebl);
    check_val("bcd4",   64'(bcd4),   64'(eb[15:0]));
    check_val("neg4",   64'(neg4),   64'(en));
    check_val("ovf4",   64'(ovf4),   64'(eo));
    check_val("blank4", 64'(blank4), 64'(ebl[3:0]));
  endtask

  // Starts one conversion; with poke set, start stays high with other data through OP and DONE.
  task automatic run_conv(input logic [BIN_W-1:0] b, input logic sm, input bit poke);
    int first_done;
    int n_done;
    @(negedge clk);
    check_val("ready_before_start", 64'(ready5 & ready4), 64'd1);
    bin         = b;
    signed_mode = sm;
    start       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (poke) begin
      bin         = ~b;
      signed_mode = ~sm;
    end else begin
      start = 1'b0;
    end
    first_done = -1;
    n_done     = 0;
    for (int n = 1; n <= BIN_W + 3; n++) begin
      @(negedge clk);
      if (done5) begin
        n_done++;
        if (first_done < 0) first_done = n;
      end
      if (n == BIN_W + 1) begin
        check_val("ready_after_done", 64'(ready5), 64'd1);
        start = 1'b0;
      end
    end
    check_val("done_latency", 64'(first_done), 64'(BIN_W));
    check_val("done_count",   64'(n_done),     64'd1);
    check_results(b, sm);
  endtask

  initial begin
    logic [BIN_W-1:0] rb;
    logic rs;
    n_checks    = 0;
    n_errors    = 0;
    reset_n     = 1'b0;
    start       = 1'b0;
    signed_mode = 1'b0;
    bin         = '0;
    repeat (3) @(negedge clk);
    check_val("rst_ready", 64'(ready5), 64'd1);
    check_val("rst_done",  64'(done5),  64'd0);
    check_val("rst_bcd",   64'(bcd5),   64'd0);
    check_val("rst_neg",   64'(neg5),   64'd0);
    check_val("rst_ovf",   64'(ovf5),   64'd0);
    check_val("rst_blank5", 64'(blank5), 64'h1e);
    check_val("rst_blank4", 64'(blank4), 64'he);
    reset_n = 1'b1;

    run_conv(16'd65535, 1'b0, 1'b0);
    check_val("max_bcd_literal", 64'(bcd5), 64'h65535);
    run_conv(16'h8000, 1'b1, 1'b0);
    check_val("minneg_bcd_literal", 64'(bcd5), 64'h32768);
    run_conv(16'd12345, 1'b0, 1'b0);
    check_val("ovf4_bcd_literal", 64'(bcd4), 64'h2345);
    check_val("ovf4_flag_literal", 64'(ovf4), 64'd1);
    run_conv(16'd0, 1'b0, 1'b0);
    check_val("zero_blank_literal", 64'(blank5), 64'h1e);
    run_conv(16'd907, 1'b0, 1'b0);
    check_val("b907_blank_literal", 64'(blank5), 64'h18);
    run_conv(16'hFFFF, 1'b1, 1'b0);
    run_conv(16'd4321, 1'b0, 1'b1);

    // Reset pulse in the middle of a conversion.
    @(negedge clk);
    bin = 16'd9999; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_val("midrst_bcd",   64'(bcd5),  64'd0);
    check_val("midrst_ready", 64'(ready5), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    begin
      int nd;
      nd = 0;
      for (int n = 0; n < BIN_W + 4; n++) begin
        @(negedge clk);
        if (done5 || done4) nd++;
      end
      check_val("midrst_no_done", 64'(nd), 64'd0);
      check_val("midrst_ready_after", 64'(ready5), 64'd1);
      check_val("midrst_ovf", 64'(ovf5), 64'd0);
    end
    run_conv(16'd2024, 1'b0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      rb = BIN_W'($urandom);
      rs = 1'($urandom_range(0, 1));
      run_conv(rb, rs, (t % 8) == 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
